// File: rtl/cve2_multdiv_arbiter.sv
// Arbitrates the shared multiplier/divider between ID/EX (port 0) and the coprocessor path (port 1).
// Latency: accept at T drives the unit from T+1; the response is valid one cycle after the unit's valid_i.
// Backpressure: one operation in flight; no new grant until the response is accepted or flushed.
module cve2_multdiv_arbiter #(
  parameter int unsigned MaxCycles = 40
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  // requester side; port r occupies slice [r*W +: W] of the packed per-port buses
  input  logic [1:0]  req_valid_i,
  output logic [1:0]  req_ready_o,
  input  logic [1:0]  req_mult_i,
  input  logic [3:0]  req_operator_i,
  input  logic [3:0]  req_signed_mode_i,
  input  logic [63:0] req_op_a_i,
  input  logic [63:0] req_op_b_i,
  output logic [1:0]  resp_valid_o,
  input  logic [1:0]  resp_ready_i,
  output logic [31:0] resp_result_o,
  output logic        resp_err_o,
  input  logic        flush_i,
  // unit side; operator_o carries the md_op_e encoding unchanged
  output logic        mult_en_o,
  output logic        div_en_o,
  output logic        mult_sel_o,
  output logic        div_sel_o,
  output logic [1:0]  operator_o,
  output logic [1:0]  signed_mode_o,
  output logic [31:0] op_a_o,
  output logic [31:0] op_b_o,
  output logic        multdiv_ready_id_o,
  input  logic        valid_i,
  input  logic [31:0] result_i,
  output logic [5:0]  last_latency_o
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP, DRAIN} state_e;

  localparam logic [5:0] CntLimit = 6'(MaxCycles - 1);

  state_e      state_q, state_d;
  logic        prio_q;
  logic        owner_q;
  logic        op_mult_q;
  logic [1:0]  op_operator_q;
  logic [1:0]  op_signed_q;
  logic [31:0] op_a_q;
  logic [31:0] op_b_q;
  logic [5:0]  cnt_q;
  logic [31:0] result_q;
  logic        err_q;
  logic [5:0]  last_lat_q;

  logic [1:0]  eligible;
  logic [1:0]  grant;
  logic        accept;
  logic        accept_port;
  logic        flush_own;
  logic        busy;
  logic        resp;

  // In IDLE a flush masks port 0's request; flush never touches port 1.
  assign eligible    = {req_valid_i[1], req_valid_i[0] & ~flush_i};
  assign flush_own   = flush_i & ~owner_q;
  assign accept      = |grant;
  assign accept_port = grant[1];
  assign busy        = (state_q == BUSY);
  assign resp        = (state_q == RESP);

  // Round-robin grant: prio breaks ties, a lone requester always wins.
  always_comb begin
    grant = 2'b00;
    if (state_q == IDLE) begin
      if (&eligible) begin
        grant = prio_q ? 2'b10 : 2'b01;
      end else begin
        grant = eligible;
      end
    end
  end

  assign req_ready_o = grant;

  // Next-state logic; flush of port 0 beats valid_i, valid_i beats the watchdog.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = BUSY;
      BUSY: begin
        if (flush_own)              state_d = DRAIN;
        else if (valid_i)           state_d = RESP;
        else if (cnt_q == CntLimit) state_d = DRAIN;
      end
      RESP: begin
        if (flush_own)                  state_d = IDLE;
        else if (resp_ready_i[owner_q]) state_d = IDLE;
      end
      DRAIN: state_d = err_q ? RESP : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Operation capture, busy counter, result/err capture and latency record.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prio_q        <= 1'b0;
      owner_q       <= 1'b0;
      op_mult_q     <= 1'b0;
      op_operator_q <= 2'b00;
      op_signed_q   <= 2'b00;
      op_a_q        <= '0;
      op_b_q        <= '0;
      cnt_q         <= '0;
      result_q      <= '0;
      err_q         <= 1'b0;
      last_lat_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            owner_q       <= accept_port;
            prio_q        <= ~accept_port;
            op_mult_q     <= req_mult_i[accept_port];
            op_operator_q <= accept_port ? req_operator_i[3:2]    : req_operator_i[1:0];
            op_signed_q   <= accept_port ? req_signed_mode_i[3:2] : req_signed_mode_i[1:0];
            op_a_q        <= accept_port ? req_op_a_i[63:32]      : req_op_a_i[31:0];
            op_b_q        <= accept_port ? req_op_b_i[63:32]      : req_op_b_i[31:0];
            cnt_q         <= '0;
            result_q      <= '0;
            err_q         <= 1'b0;
          end
        end
        BUSY: begin
          cnt_q <= (cnt_q == 6'd63) ? cnt_q : cnt_q + 6'd1;
          // A flushed operation leaves err clear so DRAIN returns to IDLE silently.
          if (!flush_own) begin
            if (valid_i) begin
              result_q   <= result_i;
              last_lat_q <= cnt_q + 6'd1;
            end else if (cnt_q == CntLimit) begin
              result_q <= '0;
              err_q    <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Unit interface is driven only while BUSY; everything else sees zeros.
  assign mult_en_o          = busy & op_mult_q;
  assign mult_sel_o         = busy & op_mult_q;
  assign div_en_o           = busy & ~op_mult_q;
  assign div_sel_o          = busy & ~op_mult_q;
  assign multdiv_ready_id_o = busy;
  assign operator_o         = busy ? op_operator_q : 2'b00;
  assign signed_mode_o      = busy ? op_signed_q   : 2'b00;
  assign op_a_o             = busy ? op_a_q        : '0;
  assign op_b_o             = busy ? op_b_q        : '0;

  assign resp_valid_o   = resp ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign resp_result_o  = resp ? result_q : '0;
  assign resp_err_o     = resp & err_q;
  assign last_latency_o = last_lat_q;

endmodule

// File: tb/tb_cve2_multdiv_arbiter.sv
// Bench for cve2_multdiv_arbiter: vector table, directed corner sequences, random scoreboard.
// Latency: the bench plays the multdiv unit with a programmable BUSY-cycle latency.
// Backpressure: resp_ready is driven per test (held low, high, or random).
module tb_cve2_multdiv_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid, req_ready, req_mult, resp_valid, resp_ready;
  logic [3:0]  req_operator, req_signed_mode;
  logic [63:0] req_op_a, req_op_b;
  logic [31:0] resp_result, op_a_o, op_b_o, result_i;
  logic        resp_err, flush;
  logic        mult_en, div_en, mult_sel, div_sel, multdiv_ready_id, valid_i;
  logic [1:0]  operator_o, signed_mode_o;
  logic [5:0]  last_latency;

  always #5 clk = ~clk;

  cve2_multdiv_arbiter #(.MaxCycles(40)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_mult_i(req_mult),
    .req_operator_i(req_operator), .req_signed_mode_i(req_signed_mode),
    .req_op_a_i(req_op_a), .req_op_b_i(req_op_b),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
    .resp_result_o(resp_result), .resp_err_o(resp_err), .flush_i(flush),
    .mult_en_o(mult_en), .div_en_o(div_en), .mult_sel_o(mult_sel), .div_sel_o(div_sel),
    .operator_o(operator_o), .signed_mode_o(signed_mode_o),
    .op_a_o(op_a_o), .op_b_o(op_b_o), .multdiv_ready_id_o(multdiv_ready_id),
    .valid_i(valid_i), .result_i(result_i), .last_latency_o(last_latency)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int unit_lat = 3;
  bit unit_hang = 1'b0;
  int busy_cnt = 0;

  // Behaviour of the fake unit: some arithmetic that depends on every operand field.
  function automatic logic [31:0] unit_fn(input logic m, input logic [1:0] op, input logic [1:0] sm,
                                          input logic [31:0] a, input logic [31:0] b);
    if (m) return a * b + {30'd0, op} + {26'd0, sm, 4'd0};
    return ((b == 32'd0) ? 32'hFFFF_FFFF : a / b) ^ {26'd0, sm, 2'd0, op};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Unit model: raises valid_i in the unit_lat-th cycle it is enabled.
  initial begin
    valid_i  = 1'b0;
    result_i = '0;
    forever begin
      @(posedge clk); #1;
      if (mult_en || div_en) begin
        busy_cnt++;
        if (!unit_hang && busy_cnt == unit_lat) begin
          valid_i  = 1'b1;
          result_i = unit_fn(mult_en, operator_o, signed_mode_o, op_a_o, op_b_o);
        end else begin
          valid_i  = 1'b0;
          result_i = 32'hDEAD_BEEF;
        end
      end else begin
        busy_cnt = 0;
        valid_i  = 1'b0;
        result_i = '0;
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #2;
  endtask

  task automatic set_req(input int p, input logic m, input logic [1:0] op, input logic [1:0] sm,
                         input logic [31:0] a, input logic [31:0] b);
    req_mult[p]               = m;
    req_operator[p*2 +: 2]    = op;
    req_signed_mode[p*2 +: 2] = sm;
    req_op_a[p*32 +: 32]      = a;
    req_op_b[p*32 +: 32]      = b;
    req_valid[p]              = 1'b1;
  endtask

  task automatic wait_grant(input int p, input string name, output logic [1:0] rdy, output int waited);
    bit got = 1'b0;
    rdy = 2'b00;
    waited = 0;
    for (int i = 0; i < 300 && !got; i++) begin
      #1;
      if (req_ready[p]) begin got = 1'b1; rdy = req_ready; end
      else waited++;
      cyc();
    end
    req_valid[p] = 1'b0;
    check(name, got, 1);
  endtask

  task automatic wait_resp(input int p, input string name, output logic [31:0] res, output logic err);
    bit got = 1'b0;
    res = '0;
    err = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      #1;
      if (resp_valid[p] && resp_ready[p]) begin got = 1'b1; res = resp_result; err = resp_err; end
      cyc();
    end
    check(name, got, 1);
  endtask

  task automatic reset_dut();
    rst_n = 1'b0; req_valid = '0; resp_ready = '0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  typedef struct {
    logic [1:0] rv;
    logic       fl;
    logic [1:0] rr;
    logic [1:0] exp_rdy;
  } vec_t;

  typedef struct {
    int         port;
    logic       m;
    logic [1:0] op, sm;
    logic [31:0] a, b;
    int         lat;
  } txn_t;

  initial begin
    vec_t vecs[10];
    logic [1:0]  rdy;
    logic [31:0] res;
    logic        err;
    int          waited, nb;
    bit          seen;
    txn_t        cur;
    bit          outst, was_outst, lat_pend, prio_m;
    int          since, lat_exp;
    logic [1:0]  exp_rdy, clear_p;

    vecs[0] = '{2'b00, 1'b0, 2'b00, 2'b00};
    vecs[1] = '{2'b01, 1'b0, 2'b00, 2'b01};
    vecs[2] = '{2'b10, 1'b0, 2'b00, 2'b10};
    vecs[3] = '{2'b11, 1'b0, 2'b00, 2'b01};
    vecs[4] = '{2'b01, 1'b1, 2'b00, 2'b00};
    vecs[5] = '{2'b11, 1'b1, 2'b00, 2'b10};
    vecs[6] = '{2'b10, 1'b1, 2'b00, 2'b10};
    vecs[7] = '{2'b00, 1'b1, 2'b00, 2'b00};
    vecs[8] = '{2'b11, 1'b0, 2'b11, 2'b01};
    vecs[9] = '{2'b01, 1'b0, 2'b10, 2'b01};

    rst_n = 1'b0; req_valid = '0; req_mult = '0; req_operator = '0; req_signed_mode = '0;
    req_op_a = '0; req_op_b = '0; resp_ready = '0; flush = 1'b0;

    // Reset state
    #3;
    check("rst_ready", req_ready, 2'b00);
    check("rst_resp_valid", resp_valid, 2'b00);
    check("rst_unit_ctl", {mult_en, div_en, mult_sel, div_sel, multdiv_ready_id}, 5'b0);
    check("rst_unit_data", {op_a_o, op_b_o}, 64'd0);
    check("rst_misc", {operator_o, signed_mode_o, resp_err, last_latency}, 11'd0);
    check("rst_result", resp_result, 32'd0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // Combinational arbitration in IDLE with prio = 0
    for (int i = 0; i < 10; i++) begin
      req_valid = vecs[i].rv; flush = vecs[i].fl; resp_ready = vecs[i].rr;
      #1;
      check($sformatf("arb_vec%0d", i), req_ready, vecs[i].exp_rdy);
      req_valid = '0; flush = 1'b0; resp_ready = '0;
      cyc();
    end

    // Port 0 MUL 7x6, unit latency 3, other requests held during the op
    unit_hang = 1'b0; unit_lat = 3;
    set_req(0, 1'b1, 2'd0, 2'd0, 32'd7, 32'd6);
    wait_grant(0, "mul_grant", rdy, waited);
    check("mul_grant_vec", rdy, 2'b01);
    set_req(0, 1'b0, 2'd2, 2'd0, 32'd100, 32'd7);
    set_req(1, 1'b0, 2'd2, 2'd0, 32'd50, 32'd5);
    for (int c = 1; c <= 3; c++) begin
      #1;
      check($sformatf("mul_busy%0d_ready", c), req_ready, 2'b00);
      check($sformatf("mul_busy%0d_ctl", c), {mult_en, mult_sel, div_en, div_sel, multdiv_ready_id}, 5'b11001);
      check($sformatf("mul_busy%0d_ops", c), {op_a_o, op_b_o}, {32'd7, 32'd6});
      check($sformatf("mul_busy%0d_resp", c), resp_valid, 2'b00);
      cyc();
    end
    #1;
    check("mul_resp_valid", resp_valid, 2'b01);
    check("mul_resp_result", {resp_err, resp_result}, {1'b0, 32'd42});
    check("mul_last_lat", last_latency, 6'd3);
    check("mul_resp_ready", req_ready, 2'b00);
    check("mul_resp_unit_off", {mult_en, div_en, multdiv_ready_id}, 3'b000);
    resp_ready = 2'b01;
    cyc();
    // prio now favours port 1
    wait_grant(1, "alt_grant1", rdy, waited);
    check("alt_grant1_vec", rdy, 2'b10);
    check("alt_grant1_immediate", waited, 0);
    resp_ready = 2'b11;
    wait_resp(1, "alt_resp1", res, err);
    check("alt_resp1_val", {err, res}, {1'b0, unit_fn(1'b0, 2'd2, 2'd0, 32'd50, 32'd5)});
    wait_grant(0, "alt_grant0", rdy, waited);
    check("alt_grant0_vec", rdy, 2'b01);
    wait_resp(0, "alt_resp0", res, err);
    check("alt_resp0_val", {err, res}, {1'b0, unit_fn(1'b0, 2'd2, 2'd0, 32'd100, 32'd7)});
    check("alt_last_lat", last_latency, 6'd3);

    // Round-robin after reset: 0, 1, then (after a lone port-0 op) 1, 0
    reset_dut();
    unit_lat = 2;
    set_req(0, 1'b0, 2'd2, 2'd1, 32'd90, 32'd9);
    set_req(1, 1'b0, 2'd3, 2'd1, 32'd91, 32'd10);
    wait_grant(0, "rr_g0", rdy, waited);
    check("rr_g0_vec", rdy, 2'b01);
    resp_ready = 2'b11;
    wait_resp(0, "rr_r0", res, err);
    wait_grant(1, "rr_g1", rdy, waited);
    check("rr_g1_vec", rdy, 2'b10);
    wait_resp(1, "rr_r1", res, err);
    check("rr_r1_val", res, unit_fn(1'b0, 2'd3, 2'd1, 32'd91, 32'd10));
    set_req(0, 1'b1, 2'd1, 2'd2, 32'd3, 32'd3);
    wait_grant(0, "rr_g2", rdy, waited);
    set_req(0, 1'b1, 2'd0, 2'd0, 32'd11, 32'd12);
    set_req(1, 1'b1, 2'd0, 2'd0, 32'd13, 32'd14);
    wait_resp(0, "rr_r2", res, err);
    wait_grant(1, "rr_g3", rdy, waited);
    check("rr_g3_vec", rdy, 2'b10);
    wait_resp(1, "rr_r3", res, err);
    check("rr_r3_val", res, 32'd182);
    wait_grant(0, "rr_g4", rdy, waited);
    check("rr_g4_vec", rdy, 2'b01);
    wait_resp(0, "rr_r4", res, err);
    check("rr_r4_val", res, 32'd132);

    // Port 1 response held 5 cycles with port 0 waiting
    resp_ready = 2'b00; unit_lat = 3;
    set_req(1, 1'b0, 2'd3, 2'd2, 32'd1000, 32'd9);
    wait_grant(1, "stall_grant", rdy, waited);
    set_req(0, 1'b1, 2'd1, 2'd0, 32'd3, 32'd4);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      #1;
      if (resp_valid[1]) seen = 1'b1;
      else begin @(posedge clk); #1; end
    end
    check("stall_seen", seen, 1);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("stall%0d_valid", k), resp_valid, 2'b10);
      check($sformatf("stall%0d_data", k), {resp_err, resp_result},
            {1'b0, unit_fn(1'b0, 2'd3, 2'd2, 32'd1000, 32'd9)});
      check($sformatf("stall%0d_nogrant", k), req_ready, 2'b00);
      @(posedge clk); #3;
    end
    resp_ready = 2'b10;
    @(posedge clk); #2;
    wait_grant(0, "stall_next_grant", rdy, waited);
    check("stall_next_immediate", waited, 0);
    resp_ready = 2'b11;
    wait_resp(0, "stall_next_resp", res, err);
    check("stall_next_val", res, 32'd13);

    // Port 0 DIV flushed in its 10th BUSY cycle, coinciding with valid_i
    unit_lat = 10;
    set_req(0, 1'b0, 2'd2, 2'd0, 32'd77, 32'd7);
    wait_grant(0, "flush_grant", rdy, waited);
    set_req(1, 1'b1, 2'd0, 2'd3, 32'd9, 32'd9);
    repeat (9) cyc();
    flush = 1'b1;
    #1;
    check("flush_cyc10_valid", {div_en, valid_i}, 2'b11);
    cyc();
    flush = 1'b0;
    #1;
    check("flush_drain_ctl", {mult_en, div_en, mult_sel, div_sel, multdiv_ready_id}, 5'b0);
    check("flush_drain_resp", resp_valid, 2'b00);
    check("flush_drain_ready", req_ready, 2'b00);
    check("flush_last_lat", last_latency, 6'd3);
    @(posedge clk); #2;
    wait_grant(1, "flush_p1_grant", rdy, waited);
    check("flush_p1_immediate", waited, 0);
    wait_resp(1, "flush_p1_resp", res, err);
    check("flush_p1_val", res, 32'd129);

    // Flush while port 0's response is pending drops it
    resp_ready = 2'b00; unit_lat = 2;
    set_req(0, 1'b1, 2'd0, 2'd0, 32'd5, 32'd5);
    wait_grant(0, "rflush_grant", rdy, waited);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      #1;
      if (resp_valid[0]) seen = 1'b1;
      else begin @(posedge clk); #1; end
    end
    check("rflush_seen", seen, 1);
    flush = 1'b1;
    @(posedge clk); #2;
    flush = 1'b0;
    #1;
    check("rflush_dropped", resp_valid, 2'b00);
    @(posedge clk); #2;

    // Watchdog: unit never answers
    unit_hang = 1'b1; resp_ready = 2'b00;
    set_req(0, 1'b1, 2'd3, 2'd1, 32'd1234, 32'd5678);
    wait_grant(0, "wd_grant", rdy, waited);
    nb = 0;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (!mult_en) break;
      nb++;
      cyc();
    end
    check("wd_busy_cycles", nb, 40);
    check("wd_drain_ctl", {mult_en, div_en, multdiv_ready_id}, 3'b000);
    check("wd_drain_resp", resp_valid, 2'b00);
    @(posedge clk); #3;
    check("wd_resp_valid", resp_valid, 2'b01);
    check("wd_resp_err", {resp_err, resp_result}, {1'b1, 32'd0});
    check("wd_last_lat", last_latency, 6'd2);
    resp_ready = 2'b01;
    @(posedge clk); #2;
    unit_hang = 1'b0;

    // valid_i in the watchdog's last cycle wins
    unit_lat = 40;
    set_req(0, 1'b0, 2'd0, 2'd0, 32'd40, 32'd8);
    wait_grant(0, "wdv_grant", rdy, waited);
    wait_resp(0, "wdv_resp", res, err);
    check("wdv_val", {err, res}, {1'b0, 32'd5});
    check("wdv_last_lat", last_latency, 6'd40);

    // Reset pulse mid-BUSY
    unit_hang = 1'b1;
    set_req(0, 1'b1, 2'd1, 2'd1, 32'hAAAA, 32'h5555);
    wait_grant(0, "mrst_grant", rdy, waited);
    repeat (3) cyc();
    rst_n = 1'b0;
    #1;
    check("mrst_unit_off", {mult_en, div_en, mult_sel, div_sel, multdiv_ready_id}, 5'b0);
    check("mrst_ops", {op_a_o, op_b_o}, 64'd0);
    check("mrst_resp_lat", {resp_valid, last_latency}, 8'd0);
    @(posedge clk); #2;
    rst_n = 1'b1; unit_hang = 1'b0; unit_lat = 4; resp_ready = 2'b11;
    set_req(0, 1'b0, 2'd2, 2'd0, 32'd60, 32'd6);
    set_req(1, 1'b0, 2'd2, 2'd0, 32'd70, 32'd7);
    wait_grant(0, "mrst_after_g0", rdy, waited);
    check("mrst_prio0", rdy, 2'b01);
    wait_resp(0, "mrst_after_r0", res, err);
    wait_grant(1, "mrst_after_g1", rdy, waited);
    wait_resp(1, "mrst_after_r1", res, err);

    // Random traffic against a transaction-level scoreboard
    reset_dut();
    outst = 1'b0; lat_pend = 1'b0; prio_m = 1'b0; since = 0; lat_exp = 0; clear_p = 2'b00;
    cur = '{0, 1'b0, 2'd0, 2'd0, 32'd0, 32'd0, 1};
    for (int cyc_n = 0; cyc_n < 1500; cyc_n++) begin
      for (int p = 0; p < 2; p++) begin
        if (clear_p[p]) req_valid[p] = 1'b0;
        if (!req_valid[p] && $urandom_range(0, 3) == 0)
          set_req(p, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  $urandom, 32'($urandom_range(0, 300)));
      end
      clear_p = 2'b00;
      resp_ready = 2'($urandom_range(0, 3));
      #1;
      if (lat_pend) begin
        check("rnd_last_lat", last_latency, 6'(lat_exp));
        lat_pend = 1'b0;
      end
      was_outst = outst;
      if (outst) since++;
      if (outst) exp_rdy = 2'b00;
      else if (&req_valid) exp_rdy = prio_m ? 2'b10 : 2'b01;
      else exp_rdy = req_valid;
      check("rnd_ready", req_ready, exp_rdy);
      if (outst) begin
        if (since <= cur.lat) begin
          check("rnd_busy_ctl", {mult_en, div_en, operator_o, signed_mode_o, resp_valid},
                {cur.m, ~cur.m, cur.op, cur.sm, 2'b00});
          check("rnd_busy_ops", {op_a_o, op_b_o}, {cur.a, cur.b});
        end else begin
          check("rnd_resp_valid", resp_valid, (cur.port == 1) ? 2'b10 : 2'b01);
          check("rnd_resp_data", {resp_err, resp_result}, {1'b0, unit_fn(cur.m, cur.op, cur.sm, cur.a, cur.b)});
          if (resp_ready[cur.port]) begin
            outst = 1'b0; lat_pend = 1'b1; lat_exp = cur.lat;
          end
        end
      end
      if (!was_outst && exp_rdy != 2'b00) begin
        cur.port = exp_rdy[1] ? 1 : 0;
        cur.m    = req_mult[cur.port];
        cur.op   = req_operator[cur.port*2 +: 2];
        cur.sm   = req_signed_mode[cur.port*2 +: 2];
        cur.a    = req_op_a[cur.port*32 +: 32];
        cur.b    = req_op_b[cur.port*32 +: 32];
        cur.lat  = $urandom_range(1, 12);
        unit_lat = cur.lat;
        outst    = 1'b1;
        since    = 0;
        prio_m   = ~exp_rdy[1];
        clear_p[cur.port] = 1'b1;
      end
      @(posedge clk); #2;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cve2_multdiv_arbiter.md
# cve2_multdiv_arbiter

Shares the single multi-cycle multiplier/divider (`cve2_multdiv_*`) between two requesters: port 0 is the ID/EX pipeline, port 1 is the coprocessor offload path. The block registers one operation at a time and drives the unit's enable, select, operator and operand inputs for the whole operation. It captures the result and returns it to the owning requester through a valid/ready handshake. It also provides a flush path for port 0 and a latency watchdog.

## Interface
Parameters:
- `MaxCycles`, default 40: the watchdog limit, in BUSY cycles, before an operation is declared hung. Legal range is 8..63.

Ports (clock and reset first). Clock `clk_i`; reset `rst_ni` is asynchronous, active-low. One clock domain.
- `clk_i` in 1: clock.
- `rst_ni` in 1: asynchronous active-low reset.
- `req_valid_i` in 2: per-port request valid.
- `req_ready_o` out 2: per-port request accept.
- `req_mult_i` in 2: per port, 1 = multiply, 0 = divide.
- `req_operator_i[r]` in `md_op_e`: per-port operator.
- `req_signed_mode_i[r]` in 2: per-port signedness.
- `req_op_a_i[r]`, `req_op_b_i[r]` in 32: per-port operands.
- `resp_valid_o` out 2: per-port response valid.
- `resp_ready_i` in 2: per-port response accept.
- `resp_result_o` out 32: shared result bus; meaningful only for the port whose `resp_valid_o` is high.
- `resp_err_o` out 1: the response is a watchdog timeout.
- `flush_i` in 1: kill port 0's in-flight operation.
- `mult_en_o`, `div_en_o` out 1: unit enables.
- `mult_sel_o`, `div_sel_o` out 1: unit selects.
- `operator_o` out `md_op_e`: operator to the unit.
- `signed_mode_o` out 2: signedness to the unit.
- `op_a_o`, `op_b_o` out 32: operands to the unit.
- `multdiv_ready_id_o` out 1: result-accept to the unit.
- `valid_i` in 1: unit result valid.
- `result_i` in 32: unit result.
- `last_latency_o` out 6: BUSY cycle count of the last completed operation.

## Operation
- FSM states: IDLE, BUSY, RESP, DRAIN.
- IDLE:
  - `req_ready_o[r]` is high only for the port chosen by arbitration.
  - Round-robin arbitration: a priority pointer `prio` (reset 0) favours its port when both ports request; otherwise the single requester wins.
  - On handshake, capture the op, operands and `owner` into registers, set `prio` to `~owner`, clear the cycle counter, and go to BUSY.
- BUSY:
  - Drive the unit from the registers: `mult_en_o`/`mult_sel_o` = op_mult; `div_en_o`/`div_sel_o` = ~op_mult; `multdiv_ready_id_o` = 1.
  - Increment the counter each cycle.
  - On `valid_i`: capture `result_i`, set `last_latency_o` = counter+1, and go to RESP.
  - When the counter reaches MaxCycles-1 without `valid_i`: result = 0, err = 1, go to DRAIN; DRAIN then goes to RESP.
- RESP:
  - `resp_valid_o[owner]` is 1; `resp_result_o` and `resp_err_o` come from registers. All unit enables are 0.
  - When `resp_ready_i[owner]` is high, go to IDLE.
- DRAIN: all enables and `multdiv_ready_id_o` are 0 for exactly one cycle, so the unit's internal FSM returns to idle; then go to IDLE (or to RESP when `err` is set).
- `flush_i`, when owner = 0:
  - In BUSY: go to DRAIN with no response.
  - In RESP: drop the response and go to IDLE.
  - In IDLE: forces `req_ready_o[0]` = 0 that cycle.
- `flush_i` never affects port 1.
- All unit outputs are 0 outside BUSY. Operand/operator outputs are held stable for the whole of BUSY.

## Timing
- Reset values: state IDLE, `prio` 0, `owner` 0, all outputs 0, `last_latency_o` 0.
- `req_ready_o` is combinational from state, `prio`, `req_valid_i` and `flush_i`. It never depends on `resp_ready_i`.
- Accept at cycle T → BUSY from T+1 (unit sees enables at T+1).
- Unit `valid_i` at cycle V → `resp_valid_o` high from V+1.
- Minimum turnaround: accept → next accept is L+2 cycles, where L is the unit latency in BUSY cycles.
- The response stays stable until accepted; `resp_valid_o` never drops without a handshake except on flush of port 0.
- Simultaneous `valid_i` and `flush_i` in BUSY with owner 0: flush wins, the result is discarded, and the next state is DRAIN.
- Simultaneous `valid_i` and watchdog expiry: `valid_i` wins (normal response).
- The counter saturates at 63; `last_latency_o` counts only completed operations, never timeouts or flushes.
- Reset asserted mid-operation: the next cycle is IDLE with all outputs 0; the pending response is lost.

## Test plan
- Port 0 MUL 7×6, unit returns `valid_i` 3 cycles after BUSY starts → `resp_valid_o` = 01 with result 42 one cycle later; `last_latency_o` = 3; `req_ready_o` = 0 until after the response handshake.
- Both ports request DIV in IDLE after reset → port 0 granted first, port 1 next. Two further simultaneous requests → port 1 granted, then port 0 (alternation).
- Port 1 response, `resp_ready_i[1]` held low 5 cycles → `resp_valid_o[1]`, result and err are stable for those 5 cycles; no new grant is given.
- Port 0 DIV, `flush_i` in the 10th BUSY cycle → exactly one DRAIN cycle with all enables 0, then IDLE; no `resp_valid_o`; a pending port 1 request is granted next.
- `valid_i` never asserted, MaxCycles = 40 → after 40 BUSY cycles, one DRAIN cycle, then RESP with `resp_err_o` = 1, result 0, `last_latency_o` unchanged.
- Reset pulse during BUSY → outputs 0 immediately (asynchronous); after release the block is in IDLE with `prio` = 0.
